pc_fetch_unit: RTL
==================

# pc_fetch_unit

Holds the architectural program counter and fetches one instruction per step from instruction memory through a ready-based handshake. Sits directly downstream of the next-PC mux: it consumes the mux's PC_new result, commits it on instruction acceptance, and feeds the current PC back to that mux and to decode. Provides stall support, halt, and sticky misalignment fault detection.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset; must be word-aligned.

Ports:
- CLK  in  1  system clock; all state changes on rising edge.
- Reset  in  1  asynchronous, active-high reset.
- PC_new  in  32  next PC from the next-PC mux (PC+4 or branch target).
- Stall  in  1  consumer not ready; holds the current instruction.
- Halt  in  1  halt request, sampled only at instruction acceptance.
- imem_req  out  1  instruction memory read request.
- imem_addr  out  32  read address; always equals PC.
- imem_ready  in  1  memory returns imem_rdata this cycle.
- imem_rdata  in  32  instruction word from memory.
- PC  out  32  current program counter.
- Instr  out  32  registered instruction word.
- Instr_valid  out  1  Instr belongs to PC and is offered to decode.
- Fault  out  1  sticky: a misaligned PC_new was committed.
- Fetch_count  out  32  number of accepted instructions.

## Operation
- States: IDLE, REQ, VALID, HALTED, FAULT.
- IDLE: entered on reset; unconditionally moves to REQ on the next edge.
- REQ: imem_req=1, imem_addr=PC. On an edge with imem_ready=1: Instr<=imem_rdata, go to VALID. Otherwise remain in REQ with the request held. There is no timeout.
- VALID: Instr_valid=1. Acceptance is VALID && !Stall.
  - Stall=1: hold; PC, Instr, and the counter remain unchanged.
  - Accept with Halt=1: Fetch_count+1, PC unchanged, go to HALTED.
  - Accept with Halt=0 and PC_new[1:0]!=0: PC<=PC_new, Fetch_count+1, Fault<=1, go to FAULT.
  - Accept otherwise: PC<=PC_new, Fetch_count+1, go to REQ.
- Halt takes priority over misalignment on the same acceptance.
- HALTED and FAULT are terminal until Reset. Outputs imem_req=0 and Instr_valid=0; PC and Instr are frozen.
- PC_new is ignored outside acceptance edges.
- Fetch_count wraps modulo 2^32 (all-ones+1 -> 0).
- imem_req and Instr_valid are decoded from registered state only. There is no combinational path from any input to any output.

## Timing
- Reset values: PC=RESET_PC, Instr=0, Instr_valid=0, imem_req=0, Fault=0, Fetch_count=0, state IDLE.
- Reset asserted mid-request or mid-VALID clears everything immediately (asynchronous). The outstanding memory response is discarded.
- After Reset deasserts: one IDLE cycle, then imem_req=1 on the second cycle.
- With zero-wait memory (imem_ready=1 in the request cycle), one instruction completes every 2 cycles: REQ, then VALID.
- Each wait state on imem_ready adds 1 cycle. Each Stall cycle in VALID adds 1 cycle.
- The new PC is visible the cycle after acceptance, together with imem_req=1 for that address.
- imem_ready while not in REQ is ignored.

## Structure
- Shared package cpu_pkg: fetch state enum (IDLE, REQ, VALID, HALTED, FAULT), XLEN=32, default RESET_PC constant.
- Single module. The FSM, PC register, instruction register, and counter are small enough that no sub-module is warranted.

## Test plan
- Reset release, RESET_PC=0, zero-wait memory returning 32'h2002_0005, Stall=0, PC_new=PC+4 -> imem_req rises in the 2nd cycle. Instr_valid pulses every 2nd cycle. PC sequence is 0,4,8. Fetch_count=3 after 3 acceptances.
- imem_ready held low 3 cycles at PC=8 -> imem_req and imem_addr=8 stable for 4 cycles. Instr_valid stays 0 until the cycle after ready.
- Stall=1 for 2 cycles in VALID with PC_new toggling -> PC, Instr, and Fetch_count unchanged. After Stall drops, PC takes the PC_new value present at acceptance.
- Accept with PC_new=32'h0000_0012 -> Fault=1, state FAULT, PC=32'h12, imem_req stays 0 until Reset.
- Accept with Halt=1 and misaligned PC_new together -> HALTED, Fault=0, PC unchanged, Fetch_count+1.
- Reset pulsed mid-REQ, then Fetch_count forced near wrap (preloaded 32'hFFFF_FFFF via run) -> all outputs return to reset values immediately; the next acceptance wraps the count to 0.

Source files
------------

// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_pkg
// Description : Shared CPU types and constants. Provides the datapath width,
//               the default reset PC, the fetch state encoding and an
//               alignment helper.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

    localparam int XLEN = 32;

    // Boot address used when the integrator does not override RESET_PC.
    localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

    // Fetch sequencer states. HALTED and FAULT are only left through reset.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_REQ    = 3'd1,
        ST_VALID  = 3'd2,
        ST_HALTED = 3'd3,
        ST_FAULT  = 3'd4
    } fetch_state_e;

    // Instructions are 32-bit words, so any set low address bit is a fault.
    function automatic logic is_misaligned(input logic [1:0] addr_lsbs);
        return (addr_lsbs != 2'b00);
    endfunction

endpackage
`default_nettype wire

// File: rtl/pc_fetch_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : pc_fetch_unit_if
// Description : Instruction-memory read channel between the fetch unit
//               (master) and instruction memory (slave). The request is held
//               until the memory answers with imem_ready.
// Revision    : 1.0 - initial release
// ============================================================================
interface pc_fetch_unit_if;
    import cpu_pkg::*;

    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_ready;
    logic [XLEN-1:0] imem_rdata;

    // Fetch side: drives the request and address, consumes the response.
    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rdata
    );

    // Memory side: observes the request and returns the instruction word.
    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rdata
    );

endinterface
`default_nettype wire

// File: rtl/pc_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : pc_fetch_unit
// Description : Architectural program counter and single-outstanding
//               instruction fetch. Requests the word at PC, registers it,
//               offers it to decode and commits PC_new from the next-PC mux
//               when decode accepts. Supports stall, halt and a sticky
//               misalignment fault. All outputs come from registers.
// Revision    : 1.0 - initial release
// ============================================================================
module pc_fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  wire logic            CLK,
    input  wire logic            Reset,
    input  wire logic [XLEN-1:0] PC_new,
    input  wire logic            Stall,
    input  wire logic            Halt,
    pc_fetch_unit_if.master      imem,
    output      logic [XLEN-1:0] PC,
    output      logic [XLEN-1:0] Instr,
    output      logic            Instr_valid,
    output      logic            Fault,
    output      logic [XLEN-1:0] Fetch_count
);

    fetch_state_e    state_q;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] instr_q;
    logic            fault_q;
    logic [XLEN-1:0] count_q;

    // Decode hands the instruction over on any VALID cycle without stall.
    logic            accept_d;
    assign accept_d = (state_q == ST_VALID) && !Stall;

    // Fetch sequencer plus the PC, instruction, fault and counter registers.
    // Reset is asynchronous so an in-flight response is dropped at once.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state_q <= ST_IDLE;
            pc_q    <= RESET_PC;
            instr_q <= '0;
            fault_q <= 1'b0;
            count_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_q <= ST_REQ;
                end

                ST_REQ: begin
                    // Request stays up with a stable address until memory answers.
                    if (imem.imem_ready) begin
                        instr_q <= imem.imem_rdata;
                        state_q <= ST_VALID;
                    end
                end

                ST_VALID: begin
                    if (accept_d) begin
                        // Counter wraps naturally at 2^XLEN.
                        count_q <= count_q + 1'b1;
                        if (Halt) begin
                            // Halt wins over a misaligned target; PC stays put.
                            state_q <= ST_HALTED;
                        end else if (is_misaligned(PC_new[1:0])) begin
                            // The bad PC is still committed so software can see it.
                            pc_q    <= PC_new;
                            fault_q <= 1'b1;
                            state_q <= ST_FAULT;
                        end else begin
                            pc_q    <= PC_new;
                            state_q <= ST_REQ;
                        end
                    end
                end

                ST_HALTED: begin
                    state_q <= ST_HALTED;
                end

                ST_FAULT: begin
                    state_q <= ST_FAULT;
                end

                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Outputs are straight decodes of registered state, no input feed-through.
    assign imem.imem_req  = (state_q == ST_REQ);
    assign imem.imem_addr = pc_q;
    assign PC             = pc_q;
    assign Instr          = instr_q;
    assign Instr_valid    = (state_q == ST_VALID);
    assign Fault          = fault_q;
    assign Fetch_count    = count_q;

endmodule
`default_nettype wire
